// File: rtl/bus_dma_master_pkg.sv
// Shared bus constants and DMA state encoding.
package bus_dma_master_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 8;
    // Slave read data appears on M_din this many cycles after the address.
    localparam int RD_LAT     = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        READ   = 3'd2,
        RDWAIT = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/bus_dma_master_if.sv
// Master-slot view of the shared bus: req/grant plus address/write/data cycle.
interface bus_dma_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              M_req;
    logic              M_grant;
    logic              M_wr;
    logic [ADDR_W-1:0] M_address;
    logic [DATA_W-1:0] M_dout;
    logic [DATA_W-1:0] M_din;

    modport master (output M_req, M_wr, M_address, M_dout, input M_grant, M_din);
    modport slave  (input M_req, M_wr, M_address, M_dout, output M_grant, M_din);
endinterface

// File: rtl/bus_dma_master_addr_gen.sv
// Transfer descriptor registers, word index and src/dst address adders; 0-cycle address decode.
// No backpressure of its own: idx only advances when the FSM reports a granted write.
module bus_dma_master_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  idx_nxt;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load_i) begin
            src_d = src_i;
            dst_d = dst_i;
            len_d = len_i;
            idx_d = '0;
        end else if (inc_i) begin
            idx_d = idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

    // Address sums wrap modulo 2^ADDR_W by truncation.
    assign src_addr_o = src_q + ADDR_W'(idx_q);
    assign dst_addr_o = dst_q + ADDR_W'(idx_q);
    assign last_o     = (idx_nxt == len_q);

endmodule

// File: rtl/bus_dma_master.sv
// Word-copy DMA bus master; 3 cycles per word once granted (READ, RDWAIT, WRITE).
// Stalls in REQ while ungranted; a write that loses grant is retried from a fresh read.
module bus_dma_master
    import bus_dma_master_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     length,
    bus_dma_master_if.master     bus,
    output logic                 busy,
    output logic                 done
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              load;
    logic              inc;
    logic              last;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign load = (state_q == IDLE) && start;
    assign inc  = (state_q == WRITE) && bus.M_grant;

    bus_dma_master_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
        .inc_i      (inc),
        .src_i      (src_addr),
        .dst_i      (dst_addr),
        .len_i      (length),
        .src_addr_o (rd_addr),
        .dst_addr_o (wr_addr),
        .last_o     (last)
    );

    always_comb begin
        buf_d = buf_q;
        if (load) begin
            buf_d = '0;
        end else if (state_q == RDWAIT) begin
            buf_d = bus.M_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (length == '0) ? DONE : REQ;
            REQ:     if (bus.M_grant) state_d = READ;
            READ:    state_d = bus.M_grant ? RDWAIT : REQ;
            RDWAIT:  state_d = WRITE;
            // Ungranted WRITE drops back to REQ; idx holds so the word is re-read.
            WRITE:   state_d = !bus.M_grant ? REQ : (last ? DONE : READ);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.M_req     = 1'b0;
        bus.M_wr      = 1'b0;
        bus.M_address = '0;
        bus.M_dout    = '0;
        busy          = (state_q != IDLE);
        done          = 1'b0;
        unique case (state_q)
            REQ, RDWAIT: bus.M_req = 1'b1;
            READ: begin
                bus.M_req     = 1'b1;
                bus.M_address = rd_addr;
            end
            WRITE: begin
                bus.M_req     = 1'b1;
                bus.M_wr      = 1'b1;
                bus.M_address = wr_addr;
                bus.M_dout    = buf_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
